// File: rtl/reconf_ctrl.sv
// rtl/reconf_ctrl.sv - partial-reconfiguration controller: quiesce, isolate, stream bitstream, release
module reconf_ctrl #(
  parameter int NUM_RR     = 3,
  parameter int ACK_TMO    = 1024,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        start_rrid,
  input  logic [15:0]       bs_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUM_RR-1:0] rc_reqn,
  input  logic [NUM_RR-1:0] rc_ackn,
  output logic [NUM_RR-1:0] is_reconfn,
  input  logic              s_prdy,
  output logic              s_crdy,
  input  logic [31:0]       s_data,
  output logic              cfg_prdy,
  input  logic              cfg_crdy,
  output logic [31:0]       cfg_data
);

  // One shared counter serves both the ack timeout and the settle wait
  localparam int CNT_MAX = (ACK_TMO > SETTLE_CYC) ? ACK_TMO : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(ACK_TMO - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ISOL, S_XFER, S_SETTLE, S_RELEASE, S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        id;
  logic [15:0]       len;
  logic [15:0]       wcnt;
  logic [CW-1:0]     cnt;
  logic [NUM_RR-1:0] sel;
  logic [NUM_RR-1:0] start_sel;
  logic              rrid_ok;
  logic              target_ack;
  logic              target_rel;
  logic              xfer;
  logic              move;

  // One-hot masks for the latched region and the region named by start
  always_comb begin
    sel       = '0;
    start_sel = '0;
    for (int i = 0; i < NUM_RR; i++) begin
      sel[i]       = (id == 3'(i));
      start_sel[i] = (start_rrid == 3'(i));
    end
  end

  // Only the target bit of rc_ackn is looked at; other regions are ignored
  assign target_ack = ((rc_ackn & sel) == '0);
  assign target_rel = ((rc_ackn & sel) == sel);
  assign rrid_ok    = ({29'd0, start_rrid} < 32'(NUM_RR));

  assign busy = (state != S_IDLE);

  // Bitstream path is a straight pass-through, closed off outside XFER
  assign xfer     = (state == S_XFER);
  assign cfg_prdy = xfer & s_prdy;
  assign s_crdy   = xfer & cfg_crdy;
  assign cfg_data = xfer ? s_data : 32'd0;
  assign move     = xfer & s_prdy & cfg_crdy;

  // Main sequencer with registered handshake outputs and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      id         <= '0;
      len        <= '0;
      wcnt       <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      rc_reqn    <= '1;
      is_reconfn <= '1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (rrid_ok) begin
              state   <= S_REQ;
              id      <= start_rrid;
              len     <= bs_len;
              cnt     <= '0;
              wcnt    <= '0;
              rc_reqn <= ~start_sel;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (target_ack) begin
            state      <= S_ISOL;
            is_reconfn <= ~sel;
          end else if (cnt == TMO_LAST) begin
            state   <= S_IDLE;
            rc_reqn <= '1;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISOL: begin
          cnt   <= '0;
          state <= (len == 16'd0) ? S_SETTLE : S_XFER;
        end
        S_XFER: begin
          if (move) begin
            wcnt <= wcnt + 16'd1;
            if (wcnt == len - 16'd1) state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state      <= S_RELEASE;
            rc_reqn    <= '1;
            is_reconfn <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          // The region may take as long as it needs to drop its ack
          if (target_rel) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reconf_ctrl.sv
// tb/tb_reconf_ctrl.sv - scoreboard bench for reconf_ctrl
module tb_reconf_ctrl;

  localparam int NUM_RR     = 3;
  localparam int ACK_TMO    = 8;
  localparam int SETTLE_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        start_rrid;
  logic [15:0]       bs_len;
  logic              busy, done, err;
  logic [NUM_RR-1:0] rc_reqn, rc_ackn, is_reconfn;
  logic              s_prdy, s_crdy, cfg_prdy, cfg_crdy;
  logic [31:0]       s_data, cfg_data;

  always #5 clk = ~clk;

  reconf_ctrl #(.NUM_RR(NUM_RR), .ACK_TMO(ACK_TMO), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .start_rrid(start_rrid), .bs_len(bs_len),
    .busy(busy), .done(done), .err(err),
    .rc_reqn(rc_reqn), .rc_ackn(rc_ackn), .is_reconfn(is_reconfn),
    .s_prdy(s_prdy), .s_crdy(s_crdy), .s_data(s_data),
    .cfg_prdy(cfg_prdy), .cfg_crdy(cfg_crdy), .cfg_data(cfg_data)
  );

  int n_chk = 0;
  int n_pass = 0;

  // source / region models and scoreboard
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  int          src_idx;
  bit          mv;
  bit          gaps;
  bit          ack_en;
  int          ack_dly;
  int          age[NUM_RR];

  // monitor accumulators
  int                done_n, err_n, busy_n, act_n, isol_n, moves;
  logic [NUM_RR-1:0] reqn_and, isol_and;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr_mon();
    done_n = 0; err_n = 0; busy_n = 0; act_n = 0; isol_n = 0; moves = 0;
    reqn_and = '1; isol_and = '1;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    src_q.delete(); exp_q.delete();
    src_idx = 0; mv = 1'b0;
    for (int i = 0; i < n; i++) begin
      src_q.push_back(base + 32'(i));
      exp_q.push_back(base + 32'(i));
    end
  endtask

  // One clock: update models after the edge, observe at the falling edge
  task automatic step();
    @(posedge clk); #1;
    if (mv && src_idx < src_q.size()) src_idx++;
    for (int i = 0; i < NUM_RR; i++) begin
      if (!rc_reqn[i]) begin
        if (ack_en && age[i] >= ack_dly) rc_ackn[i] = 1'b0;
        age[i]++;
      end else begin
        rc_ackn[i] = 1'b1;
        age[i] = 0;
      end
    end
    s_prdy   = (src_idx < src_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
    s_data   = (src_idx < src_q.size()) ? src_q[src_idx] : 32'hDEAD_BEEF;
    cfg_crdy = !gaps || ($urandom_range(0, 1) == 1);
    @(negedge clk);
    mv = cfg_prdy && cfg_crdy;
    if (!rst) begin
      reqn_and &= rc_reqn;
      isol_and &= is_reconfn;
      if (done) done_n++;
      if (err) err_n++;
      if (busy) busy_n++;
      if (cfg_prdy || s_crdy) act_n++;
      if (is_reconfn != '1) isol_n++;
      if (mv) begin
        moves++;
        if (exp_q.size() > 0) chk("cfg_word", cfg_data, exp_q.pop_front());
        else chk("extra_word_count", moves, 0);
      end
    end
  endtask

  task automatic pulse_start(input logic [2:0] rrid, input logic [15:0] len);
    start = 1'b1; start_rrid = rrid; bs_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic run_until(input string tag, input int budget, output int k);
    k = 0;
    while (done_n == 0 && err_n == 0 && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) chk({tag, "_no_end"}, done_n + err_n, 1);
  endtask

  int k;

  initial begin
    rst = 1'b1; start = 1'b0; start_rrid = '0; bs_len = '0;
    rc_ackn = '1; s_prdy = 1'b0; s_data = '0; cfg_crdy = 1'b0;
    gaps = 1'b0; ack_en = 1'b1; ack_dly = 0;
    for (int i = 0; i < NUM_RR; i++) age[i] = 0;
    load(0, 32'd0);
    clr_mon();
    repeat (2) step();
    chk("rst_reqn", rc_reqn, 3'b111);
    chk("rst_isol", is_reconfn, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_s_crdy", s_crdy, 0);
    chk("rst_cfg_prdy", cfg_prdy, 0);
    rst = 1'b0;
    step();

    // 1: basic four-word reconfiguration of region 1
    clr_mon(); load(4, 32'hC0DE_0000); ack_dly = 3;
    pulse_start(3'd1, 16'd4);
    chk("t1_req_lat", rc_reqn, 3'b101);
    chk("t1_busy", busy, 1);
    run_until("t1", 200, k);
    chk("t1_done_n", done_n, 1);
    chk("t1_err_n", err_n, 0);
    chk("t1_reqn_and", reqn_and, 3'b101);
    chk("t1_isol_and", isol_and, 3'b101);
    chk("t1_moves", moves, 4);
    chk("t1_reqn_end", rc_reqn, 3'b111);
    chk("t1_isol_end", is_reconfn, 3'b111);
    step();
    chk("t1_idle", busy, 0);

    // 2: out-of-range region ids
    clr_mon(); ack_dly = 0;
    pulse_start(3'd5, 16'd2);
    chk("t2_err5", err, 1);
    chk("t2_busy5", busy, 0);
    step();
    chk("t2_err_pulse", err, 0);
    pulse_start(3'd3, 16'd2);
    chk("t2_err3", err, 1);
    repeat (3) step();
    chk("t2_err_n", err_n, 2);
    chk("t2_busy_n", busy_n, 0);
    chk("t2_reqn_and", reqn_and, 3'b111);

    // 3: acknowledge never arrives
    clr_mon(); load(4, 32'h5000_0000); ack_en = 1'b0;
    pulse_start(3'd0, 16'd4);
    run_until("t3", 40, k);
    chk("t3_tmo_lat", k, ACK_TMO);
    chk("t3_err_n", err_n, 1);
    chk("t3_reqn", rc_reqn, 3'b111);
    chk("t3_isol_and", isol_and, 3'b111);
    chk("t3_done_n", done_n, 0);
    chk("t3_moves", moves, 0);
    chk("t3_idle", busy, 0);
    ack_en = 1'b1;
    repeat (2) step();

    // 4: empty bitstream
    clr_mon(); load(0, 32'd0);
    pulse_start(3'd2, 16'd0);
    run_until("t4", 100, k);
    chk("t4_done_n", done_n, 1);
    chk("t4_act_n", act_n, 0);
    chk("t4_isol_cycles", isol_n, 1 + SETTLE_CYC);
    chk("t4_isol_and", isol_and, 3'b011);
    step();

    // 5: stalls on both sides, plus a start that must be ignored
    clr_mon(); load(3, 32'h0000_00A0); gaps = 1'b1; ack_dly = 1;
    pulse_start(3'd1, 16'd3);
    k = 0;
    while (is_reconfn == '1 && k < 50) begin step(); k++; end
    if (k >= 50) chk("t5_no_isol", is_reconfn, 3'b101);
    pulse_start(3'd2, 16'd1);
    run_until("t5", 400, k);
    chk("t5_done_n", done_n, 1);
    chk("t5_err_n", err_n, 0);
    chk("t5_moves", moves, 3);
    chk("t5_reqn_and", reqn_and, 3'b101);
    chk("t5_left", exp_q.size(), 0);
    repeat (4) step();
    chk("t5_no_second", done_n + busy_n * 0 + (busy ? 1 : 0), 1);
    gaps = 1'b0;

    // 6: reset in the middle of a transfer, then a normal run
    clr_mon(); load(8, 32'h7700_0000); ack_dly = 0;
    pulse_start(3'd0, 16'd8);
    k = 0;
    while (moves < 2 && k < 50) begin step(); k++; end
    if (k >= 50) chk("t6_no_xfer", moves, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_reqn", rc_reqn, 3'b111);
    chk("t6_rst_isol", is_reconfn, 3'b111);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_s_crdy", s_crdy, 0);
    chk("t6_rst_cfg_prdy", cfg_prdy, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    clr_mon(); load(2, 32'h9900_0000);
    pulse_start(3'd2, 16'd2);
    run_until("t6", 200, k);
    chk("t6_done_n", done_n, 1);
    chk("t6_moves", moves, 2);
    chk("t6_reqn_and", reqn_and, 3'b011);
    chk("t6_isol_and", isol_and, 3'b011);
    chk("t6_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
